// File: rtl/hazard_forward_ctrl.sv
// Load-use hazard detection and EX-stage operand forwarding control for the 5-stage pipeline.
// Keeps shadow copies of the register-use fields held in ID/EX, EX/MEM and MEM/WB.
module hazard_forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ex_rec_t;

    // Past EX only the write side matters to forwarding, so the rs fields
    // and the load flag are not carried further down the shadow pipeline.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } wr_rec_t;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    localparam logic [1:0]        FWD_RF   = 2'b00;
    localparam logic [1:0]        FWD_WB   = 2'b01;
    localparam logic [1:0]        FWD_MEM  = 2'b10;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_rec_t          ex_q;
    ex_rec_t          ex_d;
    wr_rec_t          mem_q;
    wr_rec_t          mem_d;
    wr_rec_t          wb_q;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    // Newest producer wins; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input wr_rec_t           mem,
        input wr_rec_t           wb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem.regwrite && (mem.rd != ZERO_REG) && (mem.rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb.regwrite && (wb.rd != ZERO_REG) && (wb.rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        stall = ex_q.memread && (ex_q.rd != ZERO_REG) &&
                ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i)) && !flush_i;
    end

    // A stalled or squashed ID instruction turns into an all-zero bubble.
    always_comb begin
        ex_d = '0;
        if (!stall && !flush_i) begin
            ex_d.rs1      = id_rs1_i;
            ex_d.rs2      = id_rs2_i;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
        end
    end

    always_comb begin
        mem_d          = '0;
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    assign fwd_a_o      = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign fwd_b_o      = fwd_sel(ex_q.rs2, mem_q, wb_q);
    assign stall_o      = stall;
    assign pc_write_o   = !stall;
    assign ifid_write_o = !stall;
    assign stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: expected forward selects are queued when an
// instruction is issued into ID and compared the following cycle, when it sits in EX.
module tb_hazard_forward_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;

    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic        pc_write;
    logic        ifid_write;
    logic [15:0] stall_cnt;

    logic [1:0]  sat_fwd_a;
    logic [1:0]  sat_fwd_b;
    logic        sat_stall;
    logic        sat_pc_write;
    logic        sat_ifid_write;
    logic [3:0]  sat_stall_cnt;

    logic [3:0]  exp_q[$];
    int          checks;
    int          passes;
    int          fails;

    hazard_forward_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .stall_cnt_o(stall_cnt)
    );

    hazard_forward_ctrl #(.REG_AW(5), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .flush_i(flush),
        .fwd_a_o(sat_fwd_a), .fwd_b_o(sat_fwd_b), .stall_o(sat_stall),
        .pc_write_o(sat_pc_write), .ifid_write_o(sat_ifid_write), .stall_cnt_o(sat_stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One ID cycle: compare EX forwards against the queued entry, drive ID, check the
    // same-cycle stall outputs, then queue what this ID slot should forward once in EX.
    task automatic issue(input string tag,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl,
                         input logic exp_stall, input logic [1:0] exp_fa, input logic [1:0] exp_fb);
        logic [3:0] e;
        @(negedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, "_fwd_a"}, 32'(fwd_a), 32'(e[3:2]));
        check({tag, "_fwd_b"}, 32'(fwd_b), 32'(e[1:0]));
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        #1;
        check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        check({tag, "_pc_write"}, 32'(pc_write), 32'(!exp_stall));
        check({tag, "_ifid_write"}, 32'(ifid_write), 32'(!exp_stall));
        exp_q.push_back({exp_fa, exp_fb});
    endtask

    task automatic nop(input string tag, input logic [1:0] exp_fa, input logic [1:0] exp_fb);
        issue(tag, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_fa, exp_fb);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_fwd_a", 32'(fwd_a), 32'd0);
        check("reset_fwd_b", 32'(fwd_b), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_pc_write", 32'(pc_write), 32'd1);
        check("reset_ifid_write", 32'(ifid_write), 32'd1);
        check("reset_cnt", 32'(stall_cnt), 32'd0);
        check("reset_sat_cnt", 32'(sat_stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(4'b0000);

        nop("idle0", 2'b00, 2'b00);
        nop("idle1", 2'b00, 2'b00);

        // add x5 ; sub x6,x5,x5 ; or x8,x5,x0
        issue("fw_add", 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("fw_sub", 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10);
        issue("fw_or",  5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        nop("fw_d0", 2'b00, 2'b00);
        nop("fw_d1", 2'b00, 2'b00);

        // add x7 ; add x7 ; reader of x7 on rs2 -> newest producer
        issue("pr_p1", 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("pr_p2", 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("pr_rd", 5'd3, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10);
        nop("pr_d0", 2'b00, 2'b00);
        nop("pr_d1", 2'b00, 2'b00);

        // producers writing x0 never forward
        issue("z_p1", 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("z_p2", 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("z_rd", 5'd3, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // producer three ahead: register file already holds the value
        issue("far_p", 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("far_d0", 2'b00, 2'b00);
        nop("far_d1", 2'b00, 2'b00);
        issue("far_rd", 5'd10, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("far_d2", 2'b00, 2'b00);

        // load writing x0 followed by a reader of x0: no hazard
        issue("lz_lw",  5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("lz_use", 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        nop("lz_d0", 2'b00, 2'b00);
        nop("lz_d1", 2'b00, 2'b00);

        // lw x3 ; add x11,x3,x4 -> one stall, then forward from WB
        issue("lu_lw",   5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("lu_hold", 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        issue("lu_add",  5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        check("lu_cnt", 32'(stall_cnt), 32'd1);
        nop("lu_d0", 2'b00, 2'b00);
        nop("lu_d1", 2'b00, 2'b00);

        // same hazard with a flush in the hazard cycle
        issue("fl_lw",    5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("fl_flush", 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        issue("fl_next",  5'd3, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        check("fl_cnt", 32'(stall_cnt), 32'd1);
        check("fl_sat_cnt", 32'(sat_stall_cnt), 32'd1);
        nop("fl_d0", 2'b00, 2'b00);
        nop("fl_d1", 2'b00, 2'b00);

        // 20 back-to-back load-use hazards
        for (int i = 0; i < 20; i++) begin
            issue("sat_lw",   5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
            issue("sat_hold", 5'd3, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
            issue("sat_use",  5'd3, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        end
        check("sat_cnt4", 32'(sat_stall_cnt), 32'd15);
        check("sat_cnt16", 32'(stall_cnt), 32'd21);
        nop("sat_d0", 2'b00, 2'b00);
        nop("sat_d1", 2'b00, 2'b00);

        // async reset in the middle of a load-use hazard with a live forward
        issue("rs_add", 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        issue("rs_lw",  5'd5, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00);
        issue("rs_use", 5'd3, 5'd4, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        rst = 1'b1;
        #1;
        check("rs_stall", 32'(stall), 32'd0);
        check("rs_pc_write", 32'(pc_write), 32'd1);
        check("rs_fwd_a", 32'(fwd_a), 32'd0);
        check("rs_fwd_b", 32'(fwd_b), 32'd0);
        check("rs_cnt", 32'(stall_cnt), 32'd0);
        check("rs_sat_cnt", 32'(sat_stall_cnt), 32'd0);
        exp_q.delete();
        exp_q.push_back(4'b0000);
        @(negedge clk);
        rst = 1'b0;
        nop("post_rs0", 2'b00, 2'b00);
        nop("post_rs1", 2'b00, 2'b00);
        check("post_rs_cnt", 32'(stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
